// File: rtl/hilo_ctrl.sv
// HI/LO register controller: hands MULT/MULTU operands to an external multiplier,
// captures the 64-bit product after MUL_LATENCY cycles and serves MTHI/MTLO/MFHI/MFLO.
// Optional macro HILO_FWD_EN forwards the product to MFHI/MFLO on the completion edge.
`timescale 1ns/1ps
module hilo_ctrl #(
  parameter int unsigned MUL_LATENCY = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [2:0]  op_code,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        op_ready,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  output logic        mul_is_signed,
  output logic        mul_start,
  input  logic [63:0] mul_y
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_MTHI  = 3'd2;
  localparam logic [2:0] OP_MTLO  = 3'd3;
  localparam logic [2:0] OP_MFHI  = 3'd4;
  localparam logic [2:0] OP_MFLO  = 3'd5;

  localparam logic [5:0] LAT = 6'(MUL_LATENCY);

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        accept;

  assign busy = (state == RUN);

  // NOTE: a default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    op_ready = (state == IDLE);
`ifdef HILO_FWD_EN
    if (state == RUN && cnt == 6'd1 && (op_code == OP_MFHI || op_code == OP_MFLO))
      op_ready = 1'b1;
`endif
  end

  assign accept = op_valid && op_ready;

  // NOTE: every register here uses <= so all state updates see pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      hi            <= '0;
      lo            <= '0;
      mul_a         <= '0;
      mul_b         <= '0;
      mul_is_signed <= 1'b0;
      mul_start     <= 1'b0;
      rd_data       <= '0;
      rd_valid      <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      rd_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            case (op_code)
              OP_MULT, OP_MULTU: begin
                mul_a         <= rs_data;
                mul_b         <= rt_data;
                mul_is_signed <= (op_code == OP_MULT);
                mul_start     <= 1'b1;
                cnt           <= LAT;
                state         <= RUN;
              end
              OP_MTHI: hi <= rs_data;
              OP_MTLO: lo <= rs_data;
              OP_MFHI: begin
                rd_data  <= hi;
                rd_valid <= 1'b1;
              end
              OP_MFLO: begin
                rd_data  <= lo;
                rd_valid <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) begin
            // Completion edge: operands were held stable, so mul_y is the final product.
            hi    <= mul_y[63:32];
            lo    <= mul_y[31:0];
            state <= IDLE;
            cnt   <= '0;
`ifdef HILO_FWD_EN
            if (accept) begin
              rd_data  <= (op_code == OP_MFHI) ? mul_y[63:32] : mul_y[31:0];
              rd_valid <= 1'b1;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_ctrl.sv
// Scoreboard bench for hilo_ctrl: a driver pushes expected MFHI/MFLO results into a
// queue, a negedge monitor pops and compares on every rd_valid pulse.
`timescale 1ns/1ps
module tb_hilo_ctrl;

  localparam int L = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  op_code = 3'd0;
  logic [31:0] rs_data = '0;
  logic [31:0] rt_data = '0;
  logic        op_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_is_signed;
  logic        mul_start;
  logic [63:0] mul_y;

  always #5 clk = ~clk;

  hilo_ctrl #(.MUL_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code),
    .rs_data(rs_data), .rt_data(rt_data), .op_ready(op_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy),
    .mul_a(mul_a), .mul_b(mul_b), .mul_is_signed(mul_is_signed),
    .mul_start(mul_start), .mul_y(mul_y)
  );

  // External multiplier model: product is only visible in the last cycle before completion.
  logic [5:0]         mrem;
  logic signed [63:0] sa, sb;
  logic [63:0]        prod;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) mrem <= '0;
    else if (mul_start) mrem <= 6'(L - 1);
    else if (mrem != 6'd0) mrem <= mrem - 6'd1;
  end
  always_comb begin
    sa   = {{32{mul_a[31]}}, mul_a};
    sb   = {{32{mul_b[31]}}, mul_b};
    prod = mul_is_signed ? 64'(sa * sb) : ({32'b0, mul_a} * {32'b0, mul_b});
  end
  assign mul_y = (mrem == 6'd1) ? prod : 64'h0bad_0bad_0bad_0bad;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_rd_cyc = -1;
  logic [31:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      last_rd_cyc <= cyc;
      if (exp_q.size() == 0) check("rd_unexpected", {63'b0, rd_valid}, 64'd0);
      else check("rd_data", {32'b0, rd_data}, {32'b0, exp_q.pop_front()});
    end
  end

  task automatic issue(input logic [2:0] code, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, output int stalls, output int acc_edge);
    bit ok;
    ok = 1'b0;
    stalls = 0;
    acc_edge = -1;
    @(negedge clk);
    op_valid = 1'b1; op_code = code; rs_data = a; rt_data = b;
    for (int i = 0; i < 200; i++) begin
      #2;
      if (op_ready) begin
        ok = 1'b1;
        acc_edge = cyc + 1;
        if (code == 3'd4 || code == 3'd5) exp_q.push_back(exp);
        @(posedge clk);
        #1 op_valid = 1'b0;
        break;
      end
      stalls++;
      @(negedge clk);
    end
    if (!ok) begin
      check("issue_timeout", {63'b0, op_ready}, 64'd1);
      op_valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st, a, a2, busy_n, start_n, exp_stall, exp_lat;

    // Reset state
    #22;
    check("rst_busy", {63'b0, busy}, 64'd0);
    check("rst_ready", {63'b0, op_ready}, 64'd1);
    check("rst_rd", {31'b0, rd_valid, rd_data}, 64'd0);
    check("rst_mul_ab", {mul_a, mul_b}, 64'd0);
    check("rst_mul_ctl", {62'b0, mul_is_signed, mul_start}, 64'd0);
    @(negedge clk) rst_n = 1'b1;

    // MULTU ffffffff x ffffffff
    issue(3'd1, 32'hffffffff, 32'hffffffff, '0, st, a);
    busy_n = 0; start_n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0) check("multu_signed", {63'b0, mul_is_signed}, 64'd0);
      if (!busy) break;
      busy_n++;
      if (mul_start) start_n++;
    end
    check("multu_busy_cycles", 64'(busy_n), 64'(L));
    check("multu_start_pulse", 64'(start_n), 64'd1);
    issue(3'd5, '0, '0, 32'h00000001, st, a);
    issue(3'd4, '0, '0, 32'hfffffffe, st, a);

    // MULT ffffffff x ffffffff
    issue(3'd0, 32'hffffffff, 32'hffffffff, '0, st, a);
    check("mult_signed", {63'b0, mul_is_signed}, 64'd1);
    check("mult_operands", {mul_a, mul_b}, 64'hffffffff_ffffffff);
    issue(3'd4, '0, '0, 32'h00000000, st, a);
    issue(3'd5, '0, '0, 32'h00000001, st, a);

    // MULT 3 x fffffffe with MFHI held valid through RUN
`ifdef HILO_FWD_EN
    exp_stall = L - 1; exp_lat = L;
`else
    exp_stall = L;     exp_lat = L + 1;
`endif
    issue(3'd0, 32'h00000003, 32'hfffffffe, '0, st, a);
    issue(3'd4, '0, '0, 32'hffffffff, st, a2);
    check("fwd_stall_cycles", 64'(st), 64'(exp_stall));
    repeat (2) @(negedge clk);
    check("fwd_rd_latency", 64'(last_rd_cyc - a), 64'(exp_lat));
    issue(3'd5, '0, '0, 32'hfffffffa, st, a);

    // MTHI / MTLO back to back, then read both
    issue(3'd2, 32'h12345678, '0, '0, st, a);
    check("mthi_stall", 64'(st), 64'd0);
    issue(3'd3, 32'h9abcdef0, '0, '0, st, a2);
    check("mtlo_back_to_back", 64'(a2 - a), 64'd1);
    issue(3'd4, '0, '0, 32'h12345678, st, a);
    issue(3'd5, '0, '0, 32'h9abcdef0, st, a);

    // Reset in the middle of RUN abandons the multiply
    issue(3'd2, 32'h0000abcd, '0, '0, st, a);
    issue(3'd1, 32'h00000005, 32'h00000007, '0, st, a);
    repeat (10) @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_run_busy", {63'b0, busy}, 64'd0);
    check("rst_run_start", {63'b0, mul_start}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    issue(3'd4, '0, '0, 32'h00000000, st, a);

    // NOP is accepted immediately and leaves LO untouched
    issue(3'd6, 32'hdeadbeef, 32'hdeadbeef, '0, st, a);
    check("nop_stall", 64'(st), 64'd0);
    #1 check("nop_not_busy", {63'b0, busy}, 64'd0);
    issue(3'd5, '0, '0, 32'h00000000, st, a);

    repeat (3) @(negedge clk);
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
